serial_subtractor: RTL and testbench
====================================

# serial_subtractor

- Parametrised, bit-serial, multi-cycle subtractor computing A − B in two's- or ones'-complement mode.
- Has a start/busy/done handshake.
- Processes one bit per clock through a single full-adder cell. In ones'-complement mode it runs an end-around-carry correction pass.
- Successor to the combinational half-subtractor, ones'- and two's-complement lab blocks. Used where a WIDTH-generic, low-area subtract unit with status flags is needed.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = two's complement, 1 = ones' complement; captured with start.
- a  input  WIDTH  minuend; captured with start.
- b  input  WIDTH  subtrahend; captured with start.
- busy  output  1  high in ADD and WRAP.
- done  output  1  one-cycle pulse in DONE.
- diff  output  WIDTH  result; valid from done, held until next accepted start.
- borrow  output  1  unsigned borrow (see Operation).
- overflow  output  1  signed overflow.
- zero  output  1  result is zero.

## Operation
- Datapath: serial A + ~B, LSB first, through one full-adder cell.
  - Carry register initial value: 1 in two's mode, 0 in ones' mode.
  - Sum bit shifts into diff MSB while diff shifts right; after WIDTH shifts diff is aligned.
- FSM states: IDLE, ADD, WRAP, DONE.
- IDLE:
  - start=1 → latch a, ~b, mode, initial carry; clear bit counter; go to ADD.
  - start ignored in every other state.
- ADD: one bit per cycle for WIDTH cycles. On the last bit, record carry_out, then:
  - two's mode → DONE.
  - ones' mode and carry_out=1 → WRAP, with carry reset to 1 and the operand inputs to the cell forced to 0.
  - ones' mode and carry_out=0 → DONE.
- WRAP: WIDTH cycles rotating diff through the cell, adding the end-around carry. Result is aligned after WIDTH cycles → DONE.
- DONE: done=1 for one cycle, then IDLE unconditionally.
- Flags are registered on entry to DONE and held until the next accepted start:
  - borrow = ~carry_out of the ADD pass. In two's mode this means A < B unsigned; in ones' mode, A ≤ B unsigned.
  - overflow = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]), evaluated on the final diff; the same rule applies in both modes.
  - zero = (diff == 0), or in ones' mode also (diff == all ones), i.e. negative zero.
- Reset mid-operation: abort immediately; no done is issued.

## Timing
- Reset values:
  - state IDLE; busy 0; done 0.
  - diff 0; borrow 0; overflow 0; zero 0.
  - counter 0; carry 0.
- Start accepted at edge k:
  - busy=1 after edge k.
  - Bit i processed at edge k+1+i.
- Latency:
  - Without WRAP: done=1 in the cycle after edge k+WIDTH+1, i.e. start-to-done is WIDTH+1 cycles.
  - With WRAP: 2·WIDTH+1 cycles.
- busy falls at the same edge done rises; done and busy are never both high.
- Earliest next accepted start is the edge after done; back-to-back throughput is WIDTH+2 cycles.
- Bit counter width is $clog2(WIDTH). Terminal count is WIDTH−1; the counter wraps to 0 on ADD→WRAP.

## Structure
- Package sub_pkg holds:
  - state enum (IDLE, ADD, WRAP, DONE).
  - MODE_TWOS=1'b0, MODE_ONES=1'b1.
- Sub-module serial_sub_cell: one-bit full adder (x, y, cin → s, cout), purely combinational, instantiated once.
- Top-level holds the FSM, counter, operand and diff shift registers, and flag registers.

## Test plan
All scenarios use WIDTH=8.
- Two's mode, a=0x05, b=0x03, start at edge k → diff=0x02, borrow=0, overflow=0, zero=0; done pulse exactly 9 cycles after k.
- Two's mode, a=0x03, b=0x05 → diff=0xFE, borrow=1, overflow=0. Then a=0x80, b=0x01 → diff=0x7F, overflow=1, borrow=0.
- Ones' mode, a=0x05, b=0x03 → WRAP pass taken; diff=0x02, borrow=0; done 17 cycles after start.
- Ones' mode, a=0x05, b=0x05 → no WRAP; diff=0xFF, zero=1, borrow=1; done 9 cycles after start.
- Ones' mode, a=0x03, b=0x05 → no WRAP; diff=0xFD (−2), borrow=1, zero=0.
- start pulsed while busy → ignored, result unchanged. Reset asserted during ADD → outputs return to reset values with no done. A subsequent start → correct result.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM states and mode encodings.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    WRAP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_TWOS = 1'b0;
  localparam logic MODE_ONES = 1'b1;

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full adder; the only arithmetic in the serial subtractor.
module serial_sub_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B (two's or ones' complement) computed as A + ~B, LSB first,
// with an optional end-around-carry pass and registered status flags.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             mode_r;
  logic             carry;
  logic             add_cout;
  logic             a_msb;
  logic             b_msb;

  logic             cell_x;
  logic             cell_y;
  logic             cell_s;
  logic             cell_cout;
  logic [WIDTH-1:0] next_diff;
  logic             next_zero;
  logic             next_ovf;

  serial_sub_cell u_cell (
    .x    (cell_x),
    .y    (cell_y),
    .cin  (carry),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // WRAP rotates the partial result through the cell with the operand side held at 0
  always_comb begin
    cell_x = 1'b0;
    cell_y = 1'b0;
    if (state == ADD) begin
      cell_x = opa[0];
      cell_y = opb[0];
    end else if (state == WRAP) begin
      cell_x = diff[0];
    end
  end

  // Flags are computed from the value diff takes at the edge that enters DONE
  assign next_diff = {cell_s, diff[WIDTH-1:1]};
  assign next_zero = (next_diff == '0) ||
                     ((mode_r == MODE_ONES) && (next_diff == '1));
  assign next_ovf  = (a_msb != b_msb) && (next_diff[WIDTH-1] != a_msb);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      mode_r   <= MODE_TWOS;
      add_cout <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa      <= a;
            opb      <= ~b;
            mode_r   <= mode;
            carry    <= (mode == MODE_TWOS);
            cnt      <= '0;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            busy     <= 1'b1;
            state    <= ADD;
          end
        end

        ADD: begin
          diff  <= next_diff;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= cell_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            add_cout <= cell_cout;
            cnt      <= '0;
            // Ones' complement with a carry out needs the end-around +1
            if ((mode_r == MODE_ONES) && cell_cout) begin
              carry <= 1'b1;
              state <= WRAP;
            end else begin
              borrow   <= ~cell_cout;
              overflow <= next_ovf;
              zero     <= next_zero;
              state    <= DONE;
            end
          end
        end

        WRAP: begin
          diff  <= next_diff;
          carry <= cell_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cnt      <= '0;
            borrow   <= ~add_cout;
            overflow <= next_ovf;
            zero     <= next_zero;
            state    <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed two's/ones' cases,
// ignored starts, reset abort and back-to-back random operations.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       br;
    logic       ov;
    logic       z;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
  logic       overflow;
  logic       zero;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (done && busy) begin
        errors++;
        $display("[TB] FAIL done_busy_overlap: done=%b busy=%b, required not both high", done, busy);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Independent arithmetic reference for A - B in either complement form
  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic m);
    exp_t       e;
    logic [8:0] sum;
    logic [7:0] nb;
    nb  = ~bv;
    sum = {1'b0, av} + {1'b0, nb} + {8'd0, ~m};
    e.d = sum[7:0];
    e.lat = 9;
    if (m && sum[8]) begin
      e.d   = sum[7:0] + 8'd1;
      e.lat = 17;
    end
    e.br = ~sum[8];
    e.ov = (av[7] != bv[7]) && (e.d[7] != av[7]);
    e.z  = (e.d == 8'h00) || (m && (e.d == 8'hFF));
    return e;
  endfunction

  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic m,
                          output logic busy_seen);
    @(negedge clk);
    a = av;
    b = bv;
    mode = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_seen = busy;
  endtask

  task automatic wait_done(input int already, output int cycles, output bit to);
    cycles = already;
    to = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checks++; if (diff !== 8'h00)    begin errors++; $display("[TB] FAIL reset_diff: got %h want 00", diff); end
    checks++; if (borrow !== 1'b0)   begin errors++; $display("[TB] FAIL reset_borrow: got %b want 0", borrow); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (zero !== 1'b0)     begin errors++; $display("[TB] FAIL reset_zero: got %b want 0", zero); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_directed(input string tag, input logic [7:0] av [], input logic [7:0] bv [],
                              input logic m, input exp_t ev []);
    logic bs;
    int   cyc;
    bit   to;
    exp_t e;
    for (int i = 0; i < av.size(); i++) begin
      sb.push_back(ev[i]);
      start_op(av[i], bv[i], m, bs);
      wait_done(0, cyc, to);
      e = sb.pop_front();
      checks++; if (bs !== 1'b1) begin errors++; $display("[TB] FAIL %s[%0d]_busy: got %b want 1", tag, i, bs); end
      checks++;
      if (to) begin
        errors++; $display("[TB] FAIL %s[%0d]_timeout: no done within bound", tag, i);
      end else begin
        checks++; if (diff !== e.d)     begin errors++; $display("[TB] FAIL %s[%0d]_diff: got %h want %h", tag, i, diff, e.d); end
        checks++; if (borrow !== e.br)  begin errors++; $display("[TB] FAIL %s[%0d]_borrow: got %b want %b", tag, i, borrow, e.br); end
        checks++; if (overflow !== e.ov) begin errors++; $display("[TB] FAIL %s[%0d]_overflow: got %b want %b", tag, i, overflow, e.ov); end
        checks++; if (zero !== e.z)     begin errors++; $display("[TB] FAIL %s[%0d]_zero: got %b want %b", tag, i, zero, e.z); end
        checks++; if (cyc != e.lat)     begin errors++; $display("[TB] FAIL %s[%0d]_latency: got %0d want %0d", tag, i, cyc, e.lat); end
      end
    end
  endtask

  task automatic test_twos();
    logic [7:0] av [] = '{8'h05, 8'h03, 8'h80, 8'h07};
    logic [7:0] bv [] = '{8'h03, 8'h05, 8'h01, 8'h07};
    exp_t ev [] = '{'{8'h02, 1'b0, 1'b0, 1'b0, 9},
                    '{8'hFE, 1'b1, 1'b0, 1'b0, 9},
                    '{8'h7F, 1'b0, 1'b1, 1'b0, 9},
                    '{8'h00, 1'b0, 1'b0, 1'b1, 9}};
    run_directed("twos", av, bv, 1'b0, ev);
  endtask

  task automatic test_ones();
    logic [7:0] av [] = '{8'h05, 8'h05, 8'h03};
    logic [7:0] bv [] = '{8'h03, 8'h05, 8'h05};
    exp_t ev [] = '{'{8'h02, 1'b0, 1'b0, 1'b0, 17},
                    '{8'hFF, 1'b1, 1'b0, 1'b1, 9},
                    '{8'hFD, 1'b1, 1'b0, 1'b0, 9}};
    run_directed("ones", av, bv, 1'b1, ev);
  endtask

  task automatic test_start_while_busy();
    logic bs;
    int   cyc;
    bit   to;
    exp_t e;
    sb.push_back('{8'h02, 1'b0, 1'b0, 1'b0, 9});
    start_op(8'h05, 8'h03, 1'b0, bs);
    @(negedge clk);
    a = 8'hFF;
    b = 8'h00;
    mode = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    wait_done(3, cyc, to);
    e = sb.pop_front();
    checks++;
    if (to) begin
      errors++; $display("[TB] FAIL busy_start_timeout: no done within bound");
    end else begin
      checks++; if (diff !== e.d)   begin errors++; $display("[TB] FAIL busy_start_diff: got %h want %h", diff, e.d); end
      checks++; if (borrow !== e.br) begin errors++; $display("[TB] FAIL busy_start_borrow: got %b want %b", borrow, e.br); end
      checks++; if (cyc != e.lat)   begin errors++; $display("[TB] FAIL busy_start_latency: got %0d want %0d", cyc, e.lat); end
    end
  endtask

  task automatic test_reset_mid_op();
    logic bs;
    int   cyc;
    bit   to;
    exp_t e;
    start_op(8'h80, 8'h01, 1'b0, bs);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    checks++; if (diff !== 8'h00)    begin errors++; $display("[TB] FAIL abort_diff: got %h want 00", diff); end
    checks++; if (borrow !== 1'b0)   begin errors++; $display("[TB] FAIL abort_borrow: got %b want 0", borrow); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL abort_overflow: got %b want 0", overflow); end
    checks++; if (zero !== 1'b0)     begin errors++; $display("[TB] FAIL abort_zero: got %b want 0", zero); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done[%0d]: got %b want 0", i, done); end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_late_done[%0d]: got %b want 0", i, done); end
    end
    sb.push_back(model(8'h80, 8'h01, 1'b0));
    start_op(8'h80, 8'h01, 1'b0, bs);
    wait_done(0, cyc, to);
    e = sb.pop_front();
    checks++;
    if (to) begin
      errors++; $display("[TB] FAIL after_abort_timeout: no done within bound");
    end else begin
      checks++; if (diff !== e.d)     begin errors++; $display("[TB] FAIL after_abort_diff: got %h want %h", diff, e.d); end
      checks++; if (overflow !== e.ov) begin errors++; $display("[TB] FAIL after_abort_overflow: got %b want %b", overflow, e.ov); end
      checks++; if (cyc != e.lat)     begin errors++; $display("[TB] FAIL after_abort_latency: got %0d want %0d", cyc, e.lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic       bs;
    int         cyc;
    bit         to;
    exp_t       e;
    logic [7:0] av;
    logic [7:0] bv;
    logic       m;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) begin
        av = 8'h00; bv = 8'h00; m = 1'b1;
      end else if (i == 1) begin
        av = 8'h7F; bv = 8'h80; m = 1'b0;
      end else if (i == 2) begin
        av = 8'hFF; bv = 8'h00; m = 1'b1;
      end else begin
        av = 8'($urandom);
        bv = 8'($urandom);
        m  = 1'($urandom);
      end
      sb.push_back(model(av, bv, m));
      start_op(av, bv, m, bs);
      wait_done(0, cyc, to);
      e = sb.pop_front();
      checks++; if (bs !== 1'b1) begin errors++; $display("[TB] FAIL b2b[%0d]_accept: busy got %b want 1", i, bs); end
      checks++;
      if (to) begin
        errors++; $display("[TB] FAIL b2b[%0d]_timeout: no done within bound", i);
      end else begin
        checks++; if (diff !== e.d)     begin errors++; $display("[TB] FAIL b2b[%0d]_diff: a=%h b=%h m=%b got %h want %h", i, av, bv, m, diff, e.d); end
        checks++; if (borrow !== e.br)  begin errors++; $display("[TB] FAIL b2b[%0d]_borrow: got %b want %b", i, borrow, e.br); end
        checks++; if (overflow !== e.ov) begin errors++; $display("[TB] FAIL b2b[%0d]_overflow: got %b want %b", i, overflow, e.ov); end
        checks++; if (zero !== e.z)     begin errors++; $display("[TB] FAIL b2b[%0d]_zero: got %b want %b", i, zero, e.z); end
        checks++; if (cyc != e.lat)     begin errors++; $display("[TB] FAIL b2b[%0d]_latency: got %0d want %0d", i, cyc, e.lat); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_twos();
    test_ones();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
